// File: rtl/arcade_input_mapper_if.sv
// Input/output bundle for the arcade input mapper: PS/2 key events, joystick words,
// rotation and autofire controls in, registered active-low player words out.
interface arcade_input_mapper_if #(
    parameter int NPLAYERS = 2,
    parameter int NBUTTONS = 2
);
    localparam int W = NBUTTONS + 6;

    logic [10:0]           ps2_key;
    logic [W*NPLAYERS-1:0] joy_in;
    logic [1:0]            rotate;
    logic [NBUTTONS-1:0]   autofire_en;
    logic [W*NPLAYERS-1:0] p_out;

    modport master (output ps2_key, joy_in, rotate, autofire_en, input p_out);
    modport slave  (input ps2_key, joy_in, rotate, autofire_en, output p_out);
endinterface

// File: rtl/arcade_input_mapper.sv
// Merges PS/2 keys with joystick words, applies rotation, autofire and coin pulse shaping.
// Coin FSM (one per player):
//   state   | meaning
//   S_IDLE  | waiting for a rising edge on the raw coin bit
//   S_PULSE | coin output active for COIN_PULSE clocks
//   S_LOCK  | coin inactive, edges ignored for COIN_LOCK clocks
module arcade_input_mapper #(
    parameter int NPLAYERS     = 2,
    parameter int NBUTTONS     = 2,
    parameter int COIN_PULSE   = 1200000,
    parameter int COIN_LOCK    = 1200000,
    parameter int AUTOFIRE_DIV = 400000
) (
    input  logic                 clk_sys,
    input  logic                 reset_n,
    arcade_input_mapper_if.slave bus
);
    localparam int W    = NBUTTONS + 6;
    localparam int NW   = W * NPLAYERS;
    localparam int KIW  = $clog2(NW);
    localparam int CMAX = (COIN_PULSE > COIN_LOCK) ? COIN_PULSE : COIN_LOCK;
    localparam int TW   = $clog2(CMAX + 1);
    localparam int AW   = $clog2(AUTOFIRE_DIV + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PULSE = 2'd1;
    localparam logic [1:0] S_LOCK  = 2'd2;

    logic            r_tog;
    logic            r_armed;
    logic [NW-1:0]   r_key;
    logic            w_evt;
    logic            w_hit;
    logic [KIW-1:0]  w_kidx;
    logic [8:0]      w_code;

    assign w_code = bus.ps2_key[8:0];
    // r_armed suppresses a false event on the first clock, when r_tog is loaded from the bus
    assign w_evt  = r_armed & (bus.ps2_key[10] ^ r_tog);

    always_comb begin
        w_hit  = 1'b0;
        w_kidx = '0;
        case (w_code[7:0])
            8'h74:   begin w_hit = 1'b1; w_kidx = KIW'(0); end
            8'h6B:   begin w_hit = 1'b1; w_kidx = KIW'(1); end
            8'h72:   begin w_hit = 1'b1; w_kidx = KIW'(2); end
            8'h75:   begin w_hit = 1'b1; w_kidx = KIW'(3); end
            default: ;
        endcase
        case (w_code)
            9'h029:  begin w_hit = 1'b1; w_kidx = KIW'(4); end
            9'h014:  if (NBUTTONS >= 2) begin w_hit = 1'b1; w_kidx = KIW'(5); end
            9'h011:  if (NBUTTONS >= 3) begin w_hit = 1'b1; w_kidx = KIW'(6); end
            9'h005:  begin w_hit = 1'b1; w_kidx = KIW'(NBUTTONS + 4); end
            9'h006:  if (NPLAYERS >= 2) begin w_hit = 1'b1; w_kidx = KIW'(W + NBUTTONS + 4); end
            9'h02E:  begin w_hit = 1'b1; w_kidx = KIW'(NBUTTONS + 5); end
            9'h036:  if (NPLAYERS >= 2) begin w_hit = 1'b1; w_kidx = KIW'(W + NBUTTONS + 5); end
            default: ;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_tog   <= 1'b0;
            r_armed <= 1'b0;
            r_key   <= '0;
        end else begin
            r_tog   <= bus.ps2_key[10];
            r_armed <= 1'b1;
            if (w_evt && w_hit) r_key[w_kidx] <= bus.ps2_key[9];
        end
    end

    logic [AW-1:0] r_af_cnt;
    logic          r_af_phase;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_af_cnt   <= '0;
            r_af_phase <= 1'b1;
        end else if (r_af_cnt == AW'(AUTOFIRE_DIV - 1)) begin
            r_af_cnt   <= '0;
            r_af_phase <= ~r_af_phase;
        end else begin
            r_af_cnt   <= r_af_cnt + AW'(1);
        end
    end

    logic [NW-1:0]       w_word;
    logic [NBUTTONS-1:0] w_af_mask;

    assign w_af_mask = bus.autofire_en & {NBUTTONS{~r_af_phase}};

    for (genvar p = 0; p < NPLAYERS; p++) begin : g_player
        logic [W-1:0]  w_raw;
        logic [3:0]    w_dir;
        logic [1:0]    r_state;
        logic [TW-1:0] r_tmr;
        logic          r_coin_prev;

        assign w_raw = bus.joy_in[p*W +: W] | r_key[p*W +: W];

        // w_dir is {up, down, left, right}
        always_comb begin
            case (bus.rotate)
                2'b01:   w_dir = {w_raw[1], w_raw[0], w_raw[2], w_raw[3]};
                2'b10:   w_dir = {w_raw[2], w_raw[3], w_raw[0], w_raw[1]};
                2'b11:   w_dir = {w_raw[0], w_raw[1], w_raw[3], w_raw[2]};
                default: w_dir = w_raw[3:0];
            endcase
        end

        always_ff @(posedge clk_sys or negedge reset_n) begin
            if (!reset_n) begin
                r_state     <= S_IDLE;
                r_tmr       <= '0;
                r_coin_prev <= 1'b0;
            end else begin
                r_coin_prev <= w_raw[W-1];
                case (r_state)
                    S_IDLE:
                        if (w_raw[W-1] && !r_coin_prev) begin
                            r_state <= S_PULSE;
                            r_tmr   <= TW'(COIN_PULSE - 1);
                        end
                    S_PULSE:
                        if (r_tmr == '0) begin
                            r_state <= S_LOCK;
                            r_tmr   <= TW'(COIN_LOCK - 1);
                        end else begin
                            r_tmr   <= r_tmr - TW'(1);
                        end
                    S_LOCK:
                        if (r_tmr == '0) r_state <= S_IDLE;
                        else             r_tmr   <= r_tmr - TW'(1);
                    default: r_state <= S_IDLE;
                endcase
            end
        end

        assign w_word[p*W +: W] = {r_state == S_PULSE, w_raw[W-2],
                                   w_raw[4 +: NBUTTONS] & ~w_af_mask, w_dir};
    end

    logic [NW-1:0] r_p_out;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) r_p_out <= '1;
        else          r_p_out <= ~w_word;
    end

    assign bus.p_out = r_p_out;
endmodule

// File: tb/tb_arcade_input_mapper.sv
// Randomized scoreboard bench for arcade_input_mapper against a cycle-count reference model.
module tb_arcade_input_mapper;
    localparam int NP = 2, NB = 3, CP = 4, CL = 3, AD = 3;
    localparam int W  = NB + 6;
    localparam int NW = W * NP;
    localparam int NCYC = 3000;

    localparam logic [7:0] ARROW_CODES [4] = '{8'h74, 8'h6B, 8'h72, 8'h75};
    localparam logic [8:0] BTN_CODES   [3] = '{9'h029, 9'h014, 9'h011};
    localparam logic [8:0] START_CODES [2] = '{9'h005, 9'h006};
    localparam logic [8:0] COIN_CODES  [2] = '{9'h02E, 9'h036};
    localparam logic [8:0] PS2_POOL   [16] = '{9'h075, 9'h175, 9'h072, 9'h172, 9'h06B, 9'h074,
                                               9'h029, 9'h129, 9'h014, 9'h011, 9'h005, 9'h006,
                                               9'h02E, 9'h036, 9'h012, 9'h12E};
    // directions in clockwise order U,R,D,L mapped to word bit positions
    localparam int CIRC_BIT [4] = '{3, 0, 2, 1};

    logic clk_sys = 1'b0;
    logic reset_n = 1'b0;

    arcade_input_mapper_if #(.NPLAYERS(NP), .NBUTTONS(NB)) bus ();

    arcade_input_mapper #(
        .NPLAYERS(NP), .NBUTTONS(NB), .COIN_PULSE(CP), .COIN_LOCK(CL), .AUTOFIRE_DIV(AD)
    ) dut (
        .clk_sys(clk_sys),
        .reset_n(reset_n),
        .bus(bus)
    );

    always #5 clk_sys = ~clk_sys;

    logic [NW-1:0] exp_q [$];
    logic [NW-1:0] mon_exp;
    int  n_tests = 0;
    int  n_fail  = 0;
    bit  running = 1'b0;

    logic [NW-1:0] s_joy;
    logic [10:0]   s_ps2;
    logic [1:0]    s_rot;
    logic [NB-1:0] s_af;

    logic [W-1:0] m_key [NP];
    int           m_k;
    int           m_last [NP];
    bit           m_prev_coin [NP];
    bit           m_prev_tog;

    function automatic bit kdecode(input logic [8:0] c, output int pl, output int bi);
        bit hit = 1'b0;
        pl = 0;
        bi = 0;
        for (int i = 0; i < 4; i++)
            if (c[7:0] == ARROW_CODES[i]) begin hit = 1'b1; bi = i; end
        for (int i = 0; i < 3; i++)
            if (i < NB && c == BTN_CODES[i]) begin hit = 1'b1; bi = 4 + i; end
        for (int i = 0; i < 2; i++) begin
            if (i < NP && c == START_CODES[i]) begin hit = 1'b1; pl = i; bi = W - 2; end
            if (i < NP && c == COIN_CODES[i])  begin hit = 1'b1; pl = i; bi = W - 1; end
        end
        return hit;
    endfunction

    function automatic logic [NW-1:0] model_word(input logic [NW-1:0] joy, input logic [1:0] rot,
                                                 input logic [NB-1:0] af);
        logic [NW-1:0] w;
        logic [W-1:0]  raw;
        bit            phase;
        int            rs;
        w     = '0;
        phase = (((m_k - 1) / AD) % 2) == 0;
        rs    = int'(rot);
        for (int p = 0; p < NP; p++) begin
            raw = joy[p*W +: W] | m_key[p];
            for (int i = 0; i < 4; i++)
                w[p*W + CIRC_BIT[i]] = raw[CIRC_BIT[(i + 4 - rs) % 4]];
            for (int b = 0; b < NB; b++)
                w[p*W + 4 + b] = raw[4 + b] && (!af[b] || phase);
            w[p*W + W - 2] = raw[W-2];
            w[p*W + W - 1] = (m_k >= m_last[p] + 1) && (m_k <= m_last[p] + CP);
        end
        return ~w;
    endfunction

    task automatic model_reset();
        m_k = 0;
        for (int p = 0; p < NP; p++) begin
            m_key[p]       = '0;
            m_last[p]      = -1000;
            m_prev_coin[p] = 1'b0;
        end
    endtask

    task automatic model_step(input logic [NW-1:0] joy, input logic [10:0] ps2);
        int pl, bi;
        bit c;
        for (int p = 0; p < NP; p++) begin
            c = joy[p*W + W - 1] | m_key[p][W-1];
            if (c && !m_prev_coin[p] && m_k >= m_last[p] + CP + CL + 1) m_last[p] = m_k;
            m_prev_coin[p] = c;
        end
        if (m_k >= 2 && ps2[10] != m_prev_tog && kdecode(ps2[8:0], pl, bi))
            m_key[pl][bi] = ps2[9];
        m_prev_tog = ps2[10];
    endtask

    task automatic drive_cycle(input bit rst);
        @(negedge clk_sys);
        if ($urandom_range(0, 3) == 0) s_joy[$urandom_range(0, NW - 1)] ^= 1'b1;
        if ($urandom_range(0, 2) == 0) begin
            s_ps2[10]  = ~s_ps2[10];
            s_ps2[9]   = 1'($urandom_range(0, 1));
            s_ps2[8:0] = PS2_POOL[$urandom_range(0, 15)];
        end
        if ($urandom_range(0, 19) == 0) s_rot = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 29) == 0) s_af  = NB'($urandom_range(0, (1 << NB) - 1));
        bus.joy_in      = s_joy;
        bus.ps2_key     = s_ps2;
        bus.rotate      = s_rot;
        bus.autofire_en = s_af;
        if (rst) begin
            reset_n = 1'b0;
            model_reset();
            exp_q.push_back('1);
        end else begin
            reset_n = 1'b1;
            m_k++;
            exp_q.push_back(model_word(s_joy, s_rot, s_af));
            model_step(s_joy, s_ps2);
        end
        running = 1'b1;
    endtask

    always @(posedge clk_sys) begin
        #1;
        if (running) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL p_out_queue at %0t: DUT output with no expectation queued", $time);
            end else begin
                mon_exp = exp_q.pop_front();
                if (bus.p_out !== mon_exp) begin
                    n_fail++;
                    $display("FAIL p_out at %0t (cycle %0d rot %0d): got %h expected %h",
                             $time, m_k, s_rot, bus.p_out, mon_exp);
                end
            end
        end
    end

    initial begin
        s_joy = '0;
        s_ps2 = '0;
        s_rot = 2'b00;
        s_af  = '0;
        bus.joy_in      = s_joy;
        bus.ps2_key     = s_ps2;
        bus.rotate      = s_rot;
        bus.autofire_en = s_af;
        m_prev_tog = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) drive_cycle(1'b1);
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            if (cyc == 1500 || $urandom_range(0, 399) == 0) begin
                drive_cycle(1'b1);
                drive_cycle(1'b1);
            end
            drive_cycle(1'b0);
        end
        @(negedge clk_sys);
        running = 1'b0;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL p_out_drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
